// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key conditioning, run/lap/stop FSM, tick prescaler and
// counter-chain clear for a decimal stopwatch display.

// Synchronizes and debounces one active-low key and emits a one-cycle press pulse.
module stopwatch_key_db #(
  parameter int unsigned DB_CNT = 500000
) (
  input  logic clk,
  input  logic nclr,
  input  logic i_key,
  output logic o_press
);

  localparam int unsigned CW = $clog2(DB_CNT + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic          r_db_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CW'(1);

  // Two-flop synchronizer; idle level is released (1).
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_key;
      r_s2 <= r_s1;
    end
  end

  // Accept a level change only after DB_CNT consecutive differing samples.
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      r_db  <= 1'b1;
      r_cnt <= '0;
    end else if (r_s2 == r_db) begin
      r_cnt <= '0;
    end else if (w_cnt_inc == CW'(DB_CNT)) begin
      r_db  <= ~r_db;
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_inc;
    end
  end

  // Press pulse in the cycle after the debounced level falls; releases are ignored.
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      r_db_d  <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_db_d  <= r_db;
      r_press <= r_db_d & ~r_db;
    end
  end

  assign o_press = r_press;

endmodule

module stopwatch_ctrl #(
  parameter int unsigned DIV    = 500000,
  parameter int unsigned DB_CNT = 500000
) (
  input  logic       clk,
  input  logic       nclr,
  input  logic       key_ss,
  input  logic       key_lr,
  output logic       tick,
  output logic       cnt_nclr,
  output logic       running,
  output logic       lap_hold,
  output logic [1:0] state
);

  localparam int unsigned PW = $clog2(DIV);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_LAP  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic          w_ss_press;
  logic          w_lr_press;
  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [PW-1:0] r_pre;
  logic          r_running;
  logic          r_lap_hold;
  logic          r_cnt_nclr;
  logic          w_running_nxt;
  logic          w_lap_hold_nxt;
  logic          w_cnt_nclr_nxt;
  logic          w_tick;
  logic          w_pre_wrap;

  stopwatch_key_db #(.DB_CNT(DB_CNT)) u_db_ss (
    .clk     (clk),
    .nclr    (nclr),
    .i_key   (key_ss),
    .o_press (w_ss_press)
  );

  stopwatch_key_db #(.DB_CNT(DB_CNT)) u_db_lr (
    .clk     (clk),
    .nclr    (nclr),
    .i_key   (key_lr),
    .o_press (w_lr_press)
  );

  // State register.
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start/stop wins over lap/reset when both arrive together.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ss_press) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_ss_press)      w_state_nxt = S_STOP;
        else if (w_lr_press) w_state_nxt = S_LAP;
      end
      S_LAP: begin
        if (w_ss_press)      w_state_nxt = S_STOP;
        else if (w_lr_press) w_state_nxt = S_RUN;
      end
      S_STOP: begin
        if (w_ss_press)      w_state_nxt = S_RUN;
        else if (w_lr_press) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: status flags from the upcoming state, clear on STOP->IDLE, tick.
  always_comb begin
    w_running_nxt  = 1'b0;
    w_lap_hold_nxt = 1'b0;
    w_cnt_nclr_nxt = 1'b1;
    w_pre_wrap     = (r_pre == PW'(DIV - 1));
    w_tick         = r_running & w_pre_wrap;
    if ((w_state_nxt == S_RUN) || (w_state_nxt == S_LAP)) w_running_nxt = 1'b1;
    if (w_state_nxt == S_LAP) w_lap_hold_nxt = 1'b1;
    if ((r_state == S_STOP) && (w_state_nxt == S_IDLE)) w_cnt_nclr_nxt = 1'b0;
  end

  // Registered status outputs track the state register exactly, without decode glitches.
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      r_running  <= 1'b0;
      r_lap_hold <= 1'b0;
      r_cnt_nclr <= 1'b0;
    end else begin
      r_running  <= w_running_nxt;
      r_lap_hold <= w_lap_hold_nxt;
      r_cnt_nclr <= w_cnt_nclr_nxt;
    end
  end

  // Prescaler counts while running, freezes in STOP so a resume keeps the partial period.
  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      r_pre <= '0;
    end else if (r_running) begin
      r_pre <= w_pre_wrap ? '0 : r_pre + PW'(1);
    end else if (r_state == S_IDLE) begin
      r_pre <= '0;
    end
  end

  assign tick     = w_tick;
  assign cnt_nclr = r_cnt_nclr;
  assign running  = r_running;
  assign lap_hold = r_lap_hold;
  assign state    = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=4, DB_CNT=3.
module tb_stopwatch_ctrl;

  localparam int unsigned DIV = 4;
  localparam int unsigned DB  = 3;

  logic       clk    = 1'b0;
  logic       nclr   = 1'b0;
  logic       key_ss = 1'b1;
  logic       key_lr = 1'b1;
  logic       tick;
  logic       cnt_nclr;
  logic       running;
  logic       lap_hold;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: expected state and prescaler phase, updated per rising edge.
  logic [1:0]  m_state = 2'd0;
  int unsigned m_pre   = 0;

  stopwatch_ctrl #(.DIV(DIV), .DB_CNT(DB)) dut (
    .clk      (clk),
    .nclr     (nclr),
    .key_ss   (key_ss),
    .key_lr   (key_lr),
    .tick     (tick),
    .cnt_nclr (cnt_nclr),
    .running  (running),
    .lap_hold (lap_hold),
    .state    (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic exp_tick();
    return ((m_state == 2'd1) || (m_state == 2'd2)) && (m_pre == DIV - 1);
  endfunction

  // One rising edge, then settle to the falling edge; prescaler uses the pre-edge state.
  task automatic adv();
    @(negedge clk);
    if ((m_state == 2'd1) || (m_state == 2'd2)) m_pre = (m_pre + 1) % DIV;
    else if (m_state == 2'd0) m_pre = 0;
  endtask

  // Drive keys low and run the first DB+3 edges; the next edge is the state change.
  task automatic press_start(input logic ss, input logic lr);
    if (ss) key_ss = 1'b0;
    if (lr) key_lr = 1'b0;
    repeat (DB + 3) adv();
  endtask

  task automatic release_keys();
    key_ss = 1'b1;
    key_lr = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (state !== 2'd0)   begin n_err++; $display("FAIL rst_state: got %0d want 0", state); end
    n_cmp++; if (tick !== 1'b0)    begin n_err++; $display("FAIL rst_tick: got %b want 0", tick); end
    n_cmp++; if (cnt_nclr !== 1'b0) begin n_err++; $display("FAIL rst_cnt_nclr: got %b want 0", cnt_nclr); end
    n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL rst_running: got %b want 0", running); end
    n_cmp++; if (lap_hold !== 1'b0) begin n_err++; $display("FAIL rst_lap_hold: got %b want 0", lap_hold); end
    @(negedge clk);
    nclr = 1'b1;
    adv();
    n_cmp++; if (cnt_nclr !== 1'b1) begin n_err++; $display("FAIL rst_release_cnt_nclr: got %b want 1", cnt_nclr); end
    n_cmp++; if (state !== 2'd0)   begin n_err++; $display("FAIL rst_release_state: got %0d want 0", state); end
  endtask

  task automatic test_glitch();
    key_ss = 1'b0;
    adv();
    adv();
    key_ss = 1'b1;
    for (int i = 0; i < 12; i++) begin
      adv();
      n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL glitch_state[%0d]: got %0d want 0", i, state); end
      n_cmp++; if (tick !== 1'b0)  begin n_err++; $display("FAIL glitch_tick[%0d]: got %b want 0", i, tick); end
    end
  endtask

  task automatic test_start();
    key_ss = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      adv();
      n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL start_early_state[%0d]: got %0d want 0", i, state); end
      n_cmp++; if (tick !== 1'b0)  begin n_err++; $display("FAIL start_early_tick[%0d]: got %b want 0", i, tick); end
    end
    adv();
    m_state = 2'd1;
    n_cmp++; if (state !== 2'd1)   begin n_err++; $display("FAIL start_state: got %0d want 1", state); end
    n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL start_running: got %b want 1", running); end
    n_cmp++; if (lap_hold !== 1'b0) begin n_err++; $display("FAIL start_lap_hold: got %b want 0", lap_hold); end
    for (int j = 1; j <= 12; j++) begin
      adv();
      if (j == 3) release_keys();
      n_cmp++; if (tick !== ((j % 4) == 3)) begin n_err++; $display("FAIL start_tick[%0d]: got %b want %b", j, tick, ((j % 4) == 3)); end
    end
  endtask

  task automatic test_lap();
    press_start(1'b0, 1'b1);
    adv();
    m_state = 2'd2;
    release_keys();
    n_cmp++; if (state !== 2'd2)    begin n_err++; $display("FAIL lap_state: got %0d want 2", state); end
    n_cmp++; if (lap_hold !== 1'b1) begin n_err++; $display("FAIL lap_hold: got %b want 1", lap_hold); end
    n_cmp++; if (running !== 1'b1)  begin n_err++; $display("FAIL lap_running: got %b want 1", running); end
    n_cmp++; if (tick !== 1'b1)     begin n_err++; $display("FAIL lap_tick_edge: got %b want 1", tick); end
    for (int j = 0; j < 8; j++) begin
      adv();
      n_cmp++; if (tick !== exp_tick()) begin n_err++; $display("FAIL lap_tick[%0d]: got %b want %b", j, tick, exp_tick()); end
    end
    press_start(1'b0, 1'b1);
    adv();
    m_state = 2'd1;
    release_keys();
    n_cmp++; if (state !== 2'd1)    begin n_err++; $display("FAIL unlap_state: got %0d want 1", state); end
    n_cmp++; if (lap_hold !== 1'b0) begin n_err++; $display("FAIL unlap_hold: got %b want 0", lap_hold); end
    for (int j = 0; j < 8; j++) begin
      adv();
      n_cmp++; if (tick !== exp_tick()) begin n_err++; $display("FAIL unlap_tick[%0d]: got %b want %b", j, tick, exp_tick()); end
    end
  endtask

  task automatic test_stop_resume();
    for (int k = 0; k < 4 && m_pre != 3; k++) adv();
    press_start(1'b1, 1'b0);
    adv();
    m_state = 2'd3;
    release_keys();
    n_cmp++; if (state !== 2'd3)   begin n_err++; $display("FAIL stop_state: got %0d want 3", state); end
    n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL stop_running: got %b want 0", running); end
    for (int j = 0; j < 20; j++) begin
      adv();
      n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL stop_tick[%0d]: got %b want 0", j, tick); end
    end
    press_start(1'b1, 1'b0);
    adv();
    m_state = 2'd1;
    release_keys();
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL resume_state: got %0d want 1", state); end
    n_cmp++; if (tick !== 1'b0)  begin n_err++; $display("FAIL resume_tick0: got %b want 0", tick); end
    adv();
    n_cmp++; if (tick !== 1'b1)  begin n_err++; $display("FAIL resume_tick1: got %b want 1", tick); end
    adv();
    n_cmp++; if (tick !== 1'b0)  begin n_err++; $display("FAIL resume_tick2: got %b want 0", tick); end
    for (int j = 0; j < 6; j++) begin
      adv();
      n_cmp++; if (tick !== exp_tick()) begin n_err++; $display("FAIL resume_tick[%0d]: got %b want %b", j, tick, exp_tick()); end
    end
  endtask

  task automatic test_clear();
    press_start(1'b1, 1'b0);
    adv();
    m_state = 2'd3;
    release_keys();
    repeat (6) adv();
    press_start(1'b0, 1'b1);
    adv();
    m_state = 2'd0;
    release_keys();
    n_cmp++; if (state !== 2'd0)    begin n_err++; $display("FAIL clear_state: got %0d want 0", state); end
    n_cmp++; if (cnt_nclr !== 1'b0) begin n_err++; $display("FAIL clear_cnt_nclr_low: got %b want 0", cnt_nclr); end
    n_cmp++; if (running !== 1'b0)  begin n_err++; $display("FAIL clear_running: got %b want 0", running); end
    adv();
    n_cmp++; if (cnt_nclr !== 1'b1) begin n_err++; $display("FAIL clear_cnt_nclr_high: got %b want 1", cnt_nclr); end
    n_cmp++; if (tick !== 1'b0)     begin n_err++; $display("FAIL clear_tick: got %b want 0", tick); end
    repeat (5) adv();
    press_start(1'b1, 1'b0);
    adv();
    m_state = 2'd1;
    release_keys();
    for (int j = 1; j <= 8; j++) begin
      adv();
      n_cmp++; if (tick !== ((j % 4) == 3)) begin n_err++; $display("FAIL restart_tick[%0d]: got %b want %b", j, tick, ((j % 4) == 3)); end
      n_cmp++; if (cnt_nclr !== 1'b1) begin n_err++; $display("FAIL restart_cnt_nclr[%0d]: got %b want 1", j, cnt_nclr); end
    end
  endtask

  task automatic test_same_cycle();
    press_start(1'b1, 1'b1);
    adv();
    m_state = 2'd3;
    release_keys();
    n_cmp++; if (state !== 2'd3)    begin n_err++; $display("FAIL both_state: got %0d want 3", state); end
    n_cmp++; if (lap_hold !== 1'b0) begin n_err++; $display("FAIL both_lap_hold: got %b want 0", lap_hold); end
    repeat (6) adv();
    n_cmp++; if (state !== 2'd3)    begin n_err++; $display("FAIL both_state_after: got %0d want 3", state); end
  endtask

  task automatic test_reset_mid();
    press_start(1'b1, 1'b0);
    adv();
    m_state = 2'd1;
    release_keys();
    repeat (6) adv();
    press_start(1'b0, 1'b1);
    adv();
    m_state = 2'd2;
    release_keys();
    adv();
    adv();
    n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL mid_pre_state: got %0d want 2", state); end
    #2;
    nclr   = 1'b0;
    key_ss = 1'b0;
    #1;
    m_state = 2'd0;
    m_pre   = 0;
    n_cmp++; if (state !== 2'd0)    begin n_err++; $display("FAIL mid_rst_state: got %0d want 0", state); end
    n_cmp++; if (tick !== 1'b0)     begin n_err++; $display("FAIL mid_rst_tick: got %b want 0", tick); end
    n_cmp++; if (running !== 1'b0)  begin n_err++; $display("FAIL mid_rst_running: got %b want 0", running); end
    n_cmp++; if (lap_hold !== 1'b0) begin n_err++; $display("FAIL mid_rst_lap_hold: got %b want 0", lap_hold); end
    n_cmp++; if (cnt_nclr !== 1'b0) begin n_err++; $display("FAIL mid_rst_cnt_nclr: got %b want 0", cnt_nclr); end
    adv();
    adv();
    n_cmp++; if (cnt_nclr !== 1'b0) begin n_err++; $display("FAIL mid_rst_hold_cnt_nclr: got %b want 0", cnt_nclr); end
    nclr = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      adv();
      n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL held_key_state[%0d]: got %0d want 0", i, state); end
      if (i == 1) begin
        n_cmp++; if (cnt_nclr !== 1'b1) begin n_err++; $display("FAIL mid_release_cnt_nclr: got %b want 1", cnt_nclr); end
      end
    end
    adv();
    m_state = 2'd1;
    release_keys();
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL held_key_press: got %0d want 1", state); end
    for (int j = 1; j <= 8; j++) begin
      adv();
      n_cmp++; if (tick !== ((j % 4) == 3)) begin n_err++; $display("FAIL held_key_tick[%0d]: got %b want %b", j, tick, ((j % 4) == 3)); end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_start();
    test_lap();
    test_stop_resume();
    test_clear();
    test_same_cycle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
